// File: rtl/regfile_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_cmd_pkg
// Brief    : Opcode and FSM state encodings for the register-file sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_cmd_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_WRITE_IMM = 2'b00;
    localparam logic [OP_W-1:0] OP_COPY      = 2'b01;
    localparam logic [OP_W-1:0] OP_ADD       = 2'b10;
    localparam logic [OP_W-1:0] OP_CLEAR     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_A = 3'd1,
        S_READ_B = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_cmd_sequencer_if
// Brief    : Command handshake, read-mux and register write bus bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_cmd_sequencer_if
    import regfile_cmd_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4,
    parameter int A = 2
) ();

    logic            cmd_valid;
    logic            cmd_ready;
    logic [OP_W-1:0] cmd_op;
    logic [A-1:0]    cmd_dst;
    logic [A-1:0]    cmd_src;
    logic [W-1:0]    cmd_imm;
    logic [A-1:0]    rd_sel;
    logic [W-1:0]    rd_data;
    logic [N-1:0]    reg_we;
    logic [W-1:0]    reg_wdata;
    logic            busy;
    logic            done;
    logic            err;

    // Environment side: issues commands and supplies the read mux.
    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rd_data,
        input  cmd_ready, rd_sel, reg_we, reg_wdata, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rd_data,
        output cmd_ready, rd_sel, reg_we, reg_wdata, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/regfile_cmd_sequencer_reg_we_decoder.sv
`default_nettype none
// ============================================================================
// Module   : reg_we_decoder
// Brief    : One-hot write-enable decode; all zeros when disabled or out of range.
// Revision : 1.0 - initial release
// ============================================================================
module reg_we_decoder #(
    parameter int N = 4,
    parameter int A = 2
) (
    input  wire logic         en,
    input  wire logic [A-1:0] addr,
    output logic      [N-1:0] onehot
);

    // Addresses at or beyond N match no bit, so they decode to zero.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign onehot[i] = en && (addr == A'(i));
    end

endmodule
`default_nettype wire

// File: rtl/regfile_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_cmd_sequencer
// Brief    : Sequences WRITE_IMM / COPY / ADD / CLEAR commands onto a register file.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_cmd_sequencer
    import regfile_cmd_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4,
    parameter int A = 2
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    regfile_cmd_sequencer_if.slave    bus
);

    localparam logic [A:0] c_N = N[A:0];

    state_t          r_state;
    logic [OP_W-1:0] r_op;
    logic [A-1:0]    r_dst;
    logic [A-1:0]    r_src;
    logic [W-1:0]    r_imm;
    logic [W-1:0]    r_opa;
    logic [W-1:0]    r_opb;
    logic [W-1:0]    r_wdata_hold;

    logic            w_accept;
    logic            w_dst_oor;
    logic [W-1:0]    w_result;
    logic [N-1:0]    w_we;

    assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
    assign w_dst_oor = ({1'b0, r_dst} >= c_N);

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_WRITE_IMM: w_result = r_imm;
            OP_COPY:      w_result = r_opa;
            OP_ADD:       w_result = r_opa + r_opb;
            default:      w_result = '0;
        endcase
    end

    reg_we_decoder #(
        .N (N),
        .A (A)
    ) u_we_dec (
        .en     (r_state == S_WRITE),
        .addr   (r_dst),
        .onehot (w_we)
    );

    // Moore outputs; reset forces IDLE so every output drops asynchronously.
    assign bus.cmd_ready = (r_state == S_IDLE) && !reset;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_DONE) && w_dst_oor;
    assign bus.reg_we    = w_we;
    assign bus.reg_wdata = (r_state == S_WRITE) ? w_result : r_wdata_hold;
    assign bus.rd_sel    = (r_state == S_READ_A) ? r_src :
                           (r_state == S_READ_B) ? r_dst : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_dst        <= '0;
            r_src        <= '0;
            r_imm        <= '0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_wdata_hold <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.cmd_op;
                        r_dst <= bus.cmd_dst;
                        r_src <= bus.cmd_src;
                        r_imm <= bus.cmd_imm;
                        if (bus.cmd_op == OP_COPY || bus.cmd_op == OP_ADD) begin
                            r_state <= S_READ_A;
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_READ_A: begin
                    r_opa   <= bus.rd_data;
                    r_state <= (r_op == OP_ADD) ? S_READ_B : S_WRITE;
                end
                S_READ_B: begin
                    r_opb   <= bus.rd_data;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_wdata_hold <= w_result;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_cmd_sequencer
// Brief    : Directed self-checking bench for regfile_cmd_sequencer (N=4 and N=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_cmd_sequencer;

    localparam logic [1:0] OPW = 2'b00;
    localparam logic [1:0] OPC = 2'b01;
    localparam logic [1:0] OPA = 2'b10;
    localparam logic [1:0] OPZ = 2'b11;

    logic clk;
    logic reset;
    int   nvec;
    int   nfail;

    regfile_cmd_sequencer_if #(.W(4), .N(4), .A(2)) if4 ();
    regfile_cmd_sequencer_if #(.W(4), .N(3), .A(2)) if3 ();

    regfile_cmd_sequencer #(.W(4), .N(4), .A(2)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    regfile_cmd_sequencer #(.W(4), .N(3), .A(2)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    // Register banks modelled in the bench; no reset, written only via reg_we.
    logic [3:0] b4 [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] b3 [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (if4.reg_we[i]) b4[i] <= if4.reg_wdata;
    end
    always @(posedge clk) begin
        for (int j = 0; j < 3; j++) if (if3.reg_we[j]) b3[j] <= if3.reg_wdata;
    end

    assign if4.rd_data = b4[if4.rd_sel];
    assign if3.rd_data = b3[if3.rd_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for cmd_ready, presents one command for one accept edge, returns 1ns after it.
    task automatic issue(input bit sel3, input logic [1:0] op, input logic [1:0] dst,
                         input logic [1:0] src, input logic [3:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel3 ? if3.cmd_ready : if4.cmd_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (!(sel3 ? if3.cmd_ready : if4.cmd_ready)) begin
            nfail++;
            $display("FAIL issue_ready: cmd_ready=0 after %0d cycles, want 1", n);
        end
        if (sel3) begin
            if3.cmd_op = op; if3.cmd_dst = dst; if3.cmd_src = src; if3.cmd_imm = imm;
            if3.cmd_valid = 1'b1;
        end else begin
            if4.cmd_op = op; if4.cmd_dst = dst; if4.cmd_src = src; if4.cmd_imm = imm;
            if4.cmd_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if3.cmd_valid = 1'b0;
        if4.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({if4.cmd_ready, if4.busy, if4.done, if4.err} !== 4'b0000) begin
            nfail++;
            $display("FAIL reset_flags: ready/busy/done/err=%b want 0000",
                     {if4.cmd_ready, if4.busy, if4.done, if4.err});
        end
        nvec++;
        if ({if4.reg_we, if4.reg_wdata, if4.rd_sel} !== 10'd0) begin
            nfail++;
            $display("FAIL reset_bus: we=%b wdata=%h rd_sel=%0d want 0",
                     if4.reg_we, if4.reg_wdata, if4.rd_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        nvec++;
        if (if4.cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_release_ready: got %b want 1", if4.cmd_ready);
        end
    endtask

    task automatic test_write_imm();
        issue(1'b0, OPW, 2'd2, 2'd0, 4'hA);
        nvec++;
        if (if4.reg_we !== 4'b0100 || if4.reg_wdata !== 4'hA) begin
            nfail++;
            $display("FAIL wimm_write: we=%b wdata=%h want 0100/a", if4.reg_we, if4.reg_wdata);
        end
        @(posedge clk); #1;
        nvec++;
        if (if4.done !== 1'b1 || if4.err !== 1'b0 || if4.reg_we !== 4'b0000) begin
            nfail++;
            $display("FAIL wimm_done: done=%b err=%b we=%b want 1/0/0000",
                     if4.done, if4.err, if4.reg_we);
        end
        nvec++;
        if (b4[2] !== 4'hA || if4.reg_wdata !== 4'hA) begin
            nfail++;
            $display("FAIL wimm_r2: R2=%h wdata=%h want a/a", b4[2], if4.reg_wdata);
        end
        @(posedge clk); #1;
        nvec++;
        if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL wimm_idle: done=%b busy=%b ready=%b want 0/0/1",
                     if4.done, if4.busy, if4.cmd_ready);
        end
    endtask

    task automatic test_copy();
        issue(1'b0, OPW, 2'd1, 2'd0, 4'h3);
        issue(1'b0, OPC, 2'd3, 2'd1, 4'hF);
        nvec++;
        if (if4.rd_sel !== 2'd1 || if4.reg_we !== 4'b0000) begin
            nfail++;
            $display("FAIL copy_reada: rd_sel=%0d we=%b want 1/0000", if4.rd_sel, if4.reg_we);
        end
        @(posedge clk); #1;
        nvec++;
        if (if4.reg_we !== 4'b1000 || if4.reg_wdata !== 4'h3 || if4.rd_sel !== 2'd0) begin
            nfail++;
            $display("FAIL copy_write: we=%b wdata=%h rd_sel=%0d want 1000/3/0",
                     if4.reg_we, if4.reg_wdata, if4.rd_sel);
        end
        @(posedge clk); #1;
        nvec++;
        if (b4[3] !== 4'h3 || if4.done !== 1'b1) begin
            nfail++;
            $display("FAIL copy_r3: R3=%h done=%b want 3/1", b4[3], if4.done);
        end
    endtask

    task automatic test_add();
        int busy_cnt;
        issue(1'b0, OPW, 2'd0, 2'd0, 4'h9);
        issue(1'b0, OPW, 2'd2, 2'd0, 4'h8);
        issue(1'b0, OPA, 2'd2, 2'd0, 4'h0);
        busy_cnt = 0;
        if (if4.busy) busy_cnt++;
        @(posedge clk); #1;
        if (if4.busy) busy_cnt++;
        nvec++;
        if (if4.rd_sel !== 2'd2) begin
            nfail++;
            $display("FAIL add_readb_sel: rd_sel=%0d want 2", if4.rd_sel);
        end
        @(posedge clk); #1;
        if (if4.busy) busy_cnt++;
        nvec++;
        if (if4.reg_we !== 4'b0100 || if4.reg_wdata !== 4'h1) begin
            nfail++;
            $display("FAIL add_write: we=%b wdata=%h want 0100/1", if4.reg_we, if4.reg_wdata);
        end
        nvec++;
        if (b4[2] !== 4'h8) begin
            nfail++;
            $display("FAIL add_early: R2=%h want 8 before write edge", b4[2]);
        end
        @(posedge clk); #1;
        if (if4.busy) busy_cnt++;
        nvec++;
        if (b4[2] !== 4'h1) begin
            nfail++;
            $display("FAIL add_r2: R2=%h want 1", b4[2]);
        end
        @(posedge clk); #1;
        if (if4.busy) busy_cnt++;
        nvec++;
        if (busy_cnt !== 4) begin
            nfail++;
            $display("FAIL add_busy_cycles: got %0d want 4", busy_cnt);
        end
    endtask

    task automatic test_double_and_clear();
        issue(1'b0, OPA, 2'd3, 2'd3, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (b4[3] !== 4'h6) begin
            nfail++;
            $display("FAIL add_self: R3=%h want 6", b4[3]);
        end
        issue(1'b0, OPZ, 2'd3, 2'd0, 4'hF);
        nvec++;
        if (if4.reg_we !== 4'b1000 || if4.reg_wdata !== 4'h0) begin
            nfail++;
            $display("FAIL clear_write: we=%b wdata=%h want 1000/0", if4.reg_we, if4.reg_wdata);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int acc;
        n = 0;
        acc = 0;
        @(negedge clk);
        while (!if4.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if4.cmd_op = OPW; if4.cmd_dst = 2'd1; if4.cmd_src = 2'd0; if4.cmd_imm = 4'h5;
        if4.cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (if4.cmd_ready) acc++;
            nvec++;
            if (if4.cmd_ready !== !if4.busy) begin
                nfail++;
                $display("FAIL b2b_ready_vs_busy: cycle %0d ready=%b busy=%b", c,
                         if4.cmd_ready, if4.busy);
            end
            @(negedge clk);
        end
        if4.cmd_valid = 1'b0;
        nvec++;
        if (acc !== 4) begin
            nfail++;
            $display("FAIL b2b_accepts: got %0d want 4", acc);
        end
        repeat (3) @(negedge clk);
        nvec++;
        if (b4[1] !== 4'h5 || if4.cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_final: R1=%h ready=%b want 5/1", b4[1], if4.cmd_ready);
        end
    endtask

    task automatic test_out_of_range();
        issue(1'b1, OPW, 2'd3, 2'd0, 4'hF);
        nvec++;
        if (if3.reg_we !== 3'b000 || if3.busy !== 1'b1) begin
            nfail++;
            $display("FAIL oor_we: we=%b busy=%b want 000/1", if3.reg_we, if3.busy);
        end
        @(posedge clk); #1;
        nvec++;
        if (if3.done !== 1'b1 || if3.err !== 1'b1) begin
            nfail++;
            $display("FAIL oor_done_err: done=%b err=%b want 1/1", if3.done, if3.err);
        end
        @(posedge clk); #1;
        nvec++;
        if (if3.done !== 1'b0 || if3.err !== 1'b0) begin
            nfail++;
            $display("FAIL oor_pulse: done=%b err=%b want 0/0", if3.done, if3.err);
        end
        nvec++;
        if ({b3[0], b3[1], b3[2]} !== 12'h000) begin
            nfail++;
            $display("FAIL oor_regs: R0..R2=%h%h%h want 000", b3[0], b3[1], b3[2]);
        end
        issue(1'b1, OPW, 2'd2, 2'd0, 4'h6);
        nvec++;
        if (if3.reg_we !== 3'b100) begin
            nfail++;
            $display("FAIL n3_inrange_we: we=%b want 100", if3.reg_we);
        end
        @(posedge clk); #1;
        nvec++;
        if (b3[2] !== 4'h6 || if3.err !== 1'b0 || if3.done !== 1'b1) begin
            nfail++;
            $display("FAIL n3_inrange: R2=%h err=%b done=%b want 6/0/1", b3[2], if3.err, if3.done);
        end
    endtask

    task automatic test_reset_mid_add();
        issue(1'b0, OPW, 2'd0, 2'd0, 4'h2);
        issue(1'b0, OPW, 2'd1, 2'd0, 4'h3);
        issue(1'b0, OPA, 2'd1, 2'd0, 4'h0);
        @(posedge clk); #1;
        nvec++;
        if (if4.rd_sel !== 2'd1 || if4.busy !== 1'b1) begin
            nfail++;
            $display("FAIL rst_mid_readb: rd_sel=%0d busy=%b want 1/1", if4.rd_sel, if4.busy);
        end
        #2;
        reset = 1'b1;
        #1;
        nvec++;
        if ({if4.reg_we, if4.reg_wdata, if4.rd_sel, if4.busy, if4.done, if4.err, if4.cmd_ready}
            !== 14'd0) begin
            nfail++;
            $display("FAIL rst_mid_outputs: we=%b wdata=%h sel=%0d busy=%b done=%b err=%b rdy=%b",
                     if4.reg_we, if4.reg_wdata, if4.rd_sel, if4.busy, if4.done, if4.err,
                     if4.cmd_ready);
        end
        repeat (2) @(negedge clk);
        nvec++;
        if (b4[1] !== 4'h3 || b4[0] !== 4'h2) begin
            nfail++;
            $display("FAIL rst_mid_regs: R0=%h R1=%h want 2/3", b4[0], b4[1]);
        end
        reset = 1'b0;
        issue(1'b0, OPW, 2'd1, 2'd0, 4'h7);
        @(posedge clk); #1;
        nvec++;
        if (b4[1] !== 4'h7 || if4.done !== 1'b1) begin
            nfail++;
            $display("FAIL rst_mid_recover: R1=%h done=%b want 7/1", b4[1], if4.done);
        end
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        reset = 1'b1;
        if4.cmd_valid = 1'b0; if4.cmd_op = 2'b00; if4.cmd_dst = '0; if4.cmd_src = '0; if4.cmd_imm = '0;
        if3.cmd_valid = 1'b0; if3.cmd_op = 2'b00; if3.cmd_dst = '0; if3.cmd_src = '0; if3.cmd_imm = '0;
        test_reset();
        test_write_imm();
        test_copy();
        test_add();
        test_double_and_clear();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_add();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
